control_sequencer: RTL and testbench

Microsequencer for the MIPS control unit. Holds the current control state and computes the next one each cycle from the next-state type field of the current control word. Next-state sources are the instruction encoder's State_Sel, increment, the control word's branch target, and the fetch state. Adds memory-operation-complete (MOC) waiting with a timeout watchdog, illegal-opcode trapping and interrupt entry at fetch boundaries.

---
 rtl/control_sequencer_pkg.sv | 36 +++
 rtl/control_sequencer_if.sv | 32 +++
 rtl/control_sequencer_cond_select.sv | 28 ++
 rtl/control_sequencer.sv | 124 ++++++++++++
 tb/tb_control_sequencer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the microsequencer: state width, next-state
// type codes, condition-select codes and the fixed trap state numbers.
package control_pkg;

    localparam int STATE_W = 7;

    typedef logic [STATE_W-1:0] state_t;

    // Next-state type field of the control word
    typedef enum logic [2:0] {
        NS_ENCODE  = 3'd0,
        NS_FETCH   = 3'd1,
        NS_INC     = 3'd2,
        NS_JUMP    = 3'd3,
        NS_CJUMP   = 3'd4,
        NS_WAIT    = 3'd5,
        NS_CENCODE = 3'd6,
        NS_HALT    = 3'd7
    } ns_e;

    // Condition select field of the control word
    localparam logic [1:0] CS_MOC  = 2'd0;
    localparam logic [1:0] CS_COND = 2'd1;
    localparam logic [1:0] CS_ONE  = 2'd2;
    localparam logic [1:0] CS_IRQ  = 2'd3;

    // Fixed state numbers
    localparam state_t DEF_RESET_STATE   = state_t'(0);
    localparam state_t DEF_FETCH_STATE   = state_t'(1);
    localparam state_t DEF_ILLEGAL_STATE = state_t'(120);
    localparam state_t DEF_TIMEOUT_STATE = state_t'(121);
    localparam state_t DEF_IRQ_STATE     = state_t'(122);

    localparam int DEF_MOC_TIMEOUT = 16;

endpackage

// File: rtl/control_sequencer_if.sv
// Control-word / status bundle between the control ROM side (master)
// and the microsequencer (slave). There is no valid/ready handshake:
// the master presents a new control word every cycle, and the slave
// presents State, which addresses the next control word.
interface control_sequencer_if;
    import control_pkg::*;

    logic [STATE_W-1:0] State_Sel;
    logic [2:0]         N;
    logic [1:0]         Cond_Sel;
    logic               Inv;
    logic [STATE_W-1:0] CR_Target;
    logic               MOC;
    logic               Cond;
    logic               Irq;
    logic [STATE_W-1:0] State;
    logic               Illegal_Op;
    logic               Mem_Timeout;
    logic               Irq_Ack;
    logic               Waiting;

    modport master (
        output State_Sel, N, Cond_Sel, Inv, CR_Target, MOC, Cond, Irq,
        input  State, Illegal_Op, Mem_Timeout, Irq_Ack, Waiting
    );

    modport slave (
        input  State_Sel, N, Cond_Sel, Inv, CR_Target, MOC, Cond, Irq,
        output State, Illegal_Op, Mem_Timeout, Irq_Ack, Waiting
    );

endinterface

// File: rtl/control_sequencer_cond_select.sv
// Branch condition mux: picks MOC, Cond, constant 1 or Irq and
// optionally inverts it, giving the test bit T.
module cond_select
    import control_pkg::*;
(
    input  logic [1:0] cond_sel,
    input  logic       inv,
    input  logic       moc,
    input  logic       cond,
    input  logic       irq,
    output logic       t
);

    logic sel;

    // Select the raw condition, then apply the inversion
    always_comb begin
        sel = 1'b0;
        case (cond_sel)
            CS_MOC:  sel = moc;
            CS_COND: sel = cond;
            CS_ONE:  sel = 1'b1;
            default: sel = irq;
        endcase
        t = sel ^ inv;
    end

endmodule

// File: rtl/control_sequencer.sv
// Microsequencer: holds the current control state and picks the next
// one from the control word's next-state type. Includes MOC waiting
// with a timeout watchdog, illegal-opcode trap and interrupt entry at
// fetch boundaries. Trap/ack pulses are registered so they line up
// with the first cycle spent in the new state.
module control_sequencer
    import control_pkg::*;
#(
    parameter state_t RESET_STATE   = DEF_RESET_STATE,
    parameter state_t FETCH_STATE   = DEF_FETCH_STATE,
    parameter state_t ILLEGAL_STATE = DEF_ILLEGAL_STATE,
    parameter state_t TIMEOUT_STATE = DEF_TIMEOUT_STATE,
    parameter state_t IRQ_STATE     = DEF_IRQ_STATE,
    parameter int     MOC_TIMEOUT   = DEF_MOC_TIMEOUT
) (
    input  logic                Clk,
    input  logic                Reset_n,
    control_sequencer_if.slave  bus
);

    localparam int CNT_W = $clog2(MOC_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOC_TIMEOUT - 1);

    state_t           state_q, state_nx;
    logic [CNT_W-1:0] cnt_q, cnt_nx;
    logic             ill_q, ill_nx;
    logic             to_q, to_nx;
    logic             ack_q, ack_nx;
    logic             t;
    state_t           inc_state;
    state_t           enc_state;
    logic             enc_ill;

    cond_select u_cond_select (
        .cond_sel (bus.Cond_Sel),
        .inv      (bus.Inv),
        .moc      (bus.MOC),
        .cond     (bus.Cond),
        .irq      (bus.Irq),
        .t        (t)
    );

    // State register, wait counter and registered pulse outputs
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
            ill_q   <= 1'b0;
            to_q    <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_nx;
            cnt_q   <= cnt_nx;
            ill_q   <= ill_nx;
            to_q    <= to_nx;
            ack_q   <= ack_nx;
        end
    end

    // Next-state decode; each field is only consulted by the N types
    // that use it, so X on unused fields stays out of State
    always_comb begin
        state_nx  = state_q;
        cnt_nx    = '0;
        ill_nx    = 1'b0;
        to_nx     = 1'b0;
        ack_nx    = 1'b0;
        inc_state = state_q + state_t'(1);
        enc_state = ILLEGAL_STATE;
        enc_ill   = 1'b1;
        case (bus.N)
            NS_ENCODE, NS_CENCODE: begin
                if (bus.State_Sel != '0) begin
                    enc_state = bus.State_Sel;
                    enc_ill   = 1'b0;
                end
            end
            default: ;
        endcase
        case (bus.N)
            NS_ENCODE: begin
                state_nx = enc_state;
                ill_nx   = enc_ill;
            end
            NS_FETCH: begin
                if (bus.Irq) begin
                    state_nx = IRQ_STATE;
                    ack_nx   = 1'b1;
                end else begin
                    state_nx = FETCH_STATE;
                end
            end
            NS_INC: state_nx = inc_state;
            NS_JUMP: state_nx = bus.CR_Target;
            NS_CJUMP: state_nx = t ? bus.CR_Target : inc_state;
            NS_WAIT: begin
                if (t) begin
                    state_nx = inc_state;
                end else if (cnt_q == CNT_LAST) begin
                    state_nx = TIMEOUT_STATE;
                    to_nx    = 1'b1;
                end else begin
                    cnt_nx = cnt_q + CNT_W'(1);
                end
            end
            NS_CENCODE: begin
                if (t) begin
                    state_nx = enc_state;
                    ill_nx   = enc_ill;
                end else begin
                    state_nx = inc_state;
                end
            end
            default: state_nx = state_q;
        endcase
    end

    assign bus.State       = state_q;
    assign bus.Illegal_Op  = ill_q;
    assign bus.Mem_Timeout = to_q;
    assign bus.Irq_Ack     = ack_q;
    assign bus.Waiting     = (bus.N == NS_WAIT) & ~t;

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer: directed steps from the test plan
// followed by randomized control words, all checked against a
// behavioural model of the next-state rules.
module tb_control_sequencer;
    import control_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    // Reference model state
    int   m_state;
    int   m_wait;
    logic m_ill, m_to, m_ack;

    control_sequencer_if bus ();

    control_sequencer dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_wait  = 0;
        m_ill   = 1'b0;
        m_to    = 1'b0;
        m_ack   = 1'b0;
    endtask

    function automatic logic model_t(input logic [1:0] cs, input logic inv,
                                     input logic moc, input logic cond, input logic irq);
        logic c;
        if (cs == 2'd0)      c = moc;
        else if (cs == 2'd1) c = cond;
        else if (cs == 2'd2) c = 1'b1;
        else                 c = irq;
        return c ^ inv;
    endfunction

    // Advance the model by one clock using the architectural rules
    task automatic model_clock(input int n, input int sel, input int tgt, input logic t,
                               input logic irq);
        int inc;
        inc   = (m_state + 1) % 128;
        m_ill = 1'b0;
        m_to  = 1'b0;
        m_ack = 1'b0;
        if (n != 5) m_wait = 0;
        case (n)
            0: if (sel != 0) m_state = sel; else begin m_state = 120; m_ill = 1'b1; end
            1: if (irq) begin m_state = 122; m_ack = 1'b1; end else m_state = 1;
            2: m_state = inc;
            3: m_state = tgt;
            4: m_state = t ? tgt : inc;
            5: begin
                if (t) begin
                    m_state = inc;
                    m_wait  = 0;
                end else if (m_wait == DEF_MOC_TIMEOUT - 1) begin
                    m_state = 121;
                    m_to    = 1'b1;
                    m_wait  = 0;
                end else begin
                    m_wait++;
                end
            end
            6: begin
                if (!t) m_state = inc;
                else if (sel != 0) m_state = sel;
                else begin m_state = 120; m_ill = 1'b1; end
            end
            default: ;
        endcase
    endtask

    // Drive one control word (called at the falling edge), check Waiting,
    // clock it, then check State and the pulses at the next falling edge
    task automatic step(input int n, input int sel, input int tgt, input int cs,
                        input logic inv, input logic moc, input logic cond, input logic irq);
        logic t;
        bus.N         = 3'(n);
        bus.State_Sel = 7'(sel);
        bus.CR_Target = 7'(tgt);
        bus.Cond_Sel  = 2'(cs);
        bus.Inv       = inv;
        bus.MOC       = moc;
        bus.Cond      = cond;
        bus.Irq       = irq;
        t = model_t(2'(cs), inv, moc, cond, irq);
        #1;
        chk("waiting", {31'd0, bus.Waiting}, {31'd0, (n == 5) && !t});
        @(posedge clk);
        model_clock(n, sel, tgt, t, irq);
        @(negedge clk);
        chk("state", {25'd0, bus.State}, 32'(m_state));
        chk("illegal_op", {31'd0, bus.Illegal_Op}, {31'd0, m_ill});
        chk("mem_timeout", {31'd0, bus.Mem_Timeout}, {31'd0, m_to});
        chk("irq_ack", {31'd0, bus.Irq_Ack}, {31'd0, m_ack});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        model_reset();
        rst_n         = 1'b0;
        bus.N         = 3'd2;
        bus.State_Sel = '0;
        bus.CR_Target = '0;
        bus.Cond_Sel  = '0;
        bus.Inv       = 1'b0;
        bus.MOC       = 1'b0;
        bus.Cond      = 1'b0;
        bus.Irq       = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_state", {25'd0, bus.State}, 32'd0);
        chk("rst_pulses", {29'd0, bus.Illegal_Op, bus.Mem_Timeout, bus.Irq_Ack}, 32'd0);
        rst_n = 1'b1;

        // Increment from reset: 1, 2, 3
        for (int i = 1; i <= 3; i++) begin
            step(2, 0, 0, 0, 0, 0, 0, 0);
            chk("inc_seq", {25'd0, bus.State}, 32'(i));
        end

        // Encode: legal and illegal
        step(3, 0, 1, 0, 0, 0, 0, 0);
        step(0, 33, 0, 0, 0, 0, 0, 0);
        chk("encode_33", {25'd0, bus.State}, 32'd33);
        step(3, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("encode_illegal", {25'd0, bus.State}, 32'd120);
        chk("illegal_pulse", {31'd0, bus.Illegal_Op}, 32'd1);
        step(2, 0, 0, 0, 0, 0, 0, 0);
        chk("illegal_pulse_end", {31'd0, bus.Illegal_Op}, 32'd0);

        // MOC wait: 4 held cycles then MOC
        step(3, 0, 10, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(5, 0, 0, 0, 0, 0, 0, 0);
            chk("wait_hold", {25'd0, bus.State}, 32'd10);
        end
        step(5, 0, 0, 0, 0, 1, 0, 0);
        chk("wait_done", {25'd0, bus.State}, 32'd11);

        // MOC never arrives: timeout after 16 held cycles
        for (int i = 0; i < 15; i++) step(5, 0, 0, 0, 0, 0, 0, 0);
        chk("timeout_pre", {25'd0, bus.State}, 32'd11);
        step(5, 0, 0, 0, 0, 0, 0, 0);
        chk("timeout_state", {25'd0, bus.State}, 32'd121);
        chk("timeout_pulse", {31'd0, bus.Mem_Timeout}, 32'd1);

        // MOC on the final cycle wins over the timeout
        step(3, 0, 20, 0, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++) step(5, 0, 0, 0, 0, 0, 0, 0);
        step(5, 0, 0, 0, 0, 1, 0, 0);
        chk("moc_wins_state", {25'd0, bus.State}, 32'd21);
        chk("moc_wins_pulse", {31'd0, bus.Mem_Timeout}, 32'd0);

        // Conditional jump, inverted condition, wrap-around
        step(4, 0, 50, 1, 0, 0, 1, 0);
        chk("cjump_taken", {25'd0, bus.State}, 32'd50);
        step(4, 0, 90, 1, 1, 0, 1, 0);
        chk("cjump_inv", {25'd0, bus.State}, 32'd51);
        step(3, 0, 127, 0, 0, 0, 0, 0);
        step(2, 0, 0, 0, 0, 0, 0, 0);
        chk("inc_wrap", {25'd0, bus.State}, 32'd0);

        // Fetch with and without interrupt; Irq ignored elsewhere
        step(2, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 1);
        chk("irq_entry", {25'd0, bus.State}, 32'd122);
        chk("irq_ack", {31'd0, bus.Irq_Ack}, 32'd1);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("fetch", {25'd0, bus.State}, 32'd1);
        chk("irq_ack_end", {31'd0, bus.Irq_Ack}, 32'd0);

        // Halt holds regardless of Irq
        for (int i = 0; i < 5; i++) begin
            step(7, 5, 9, 2, 0, 1, 1, 1);
            chk("halt_hold", {25'd0, bus.State}, 32'd1);
        end

        // Asynchronous reset in the middle of a wait
        step(3, 0, 40, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(5, 0, 0, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", {25'd0, bus.State}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) step(5, 0, 0, 0, 0, 0, 0, 0);
        chk("post_rst_hold", {25'd0, bus.State}, 32'd0);
        step(5, 0, 0, 0, 0, 0, 0, 0);
        chk("post_rst_timeout", {25'd0, bus.State}, 32'd121);

        // Randomized control words (HALT excluded so the run keeps moving)
        for (int i = 0; i < 600; i++) begin
            int n;
            int cs;
            logic moc;
            if ($urandom_range(0, 9) < 4) begin
                n   = 5;
                cs  = 0;
                moc = ($urandom_range(0, 19) == 0);
            end else begin
                n   = $urandom_range(0, 6);
                cs  = $urandom_range(0, 3);
                moc = 1'($urandom);
            end
            step(n, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 127),
                 $urandom_range(0, 127), cs, ($urandom_range(0, 3) == 0), moc,
                 1'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
